// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the I/D memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int D_BURST_DEF = 4;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: D-priority owner selection with a forced I grant after D_BURST D grants
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int D_BURST = D_BURST_DEF,
  parameter int SW = $clog2(D_BURST + 1)
) (
  input  logic          i_req_i,
  input  logic          d_req_i,
  input  logic [SW-1:0] d_streak_i,
  output logic          own_o
);
  localparam logic [SW-1:0] D_MAX = SW'(D_BURST);
  always_comb own_o = (d_req_i && !(i_req_i && d_streak_i == D_MAX)) ? OWN_D : OWN_I;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-fetch and D load/store onto one memory port with timeout abort
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int D_BURST = D_BURST_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);
  localparam int SW = $clog2(D_BURST + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] D_MAX = SW'(D_BURST);
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
  state_e state_q, state_d;
  logic own_q, own_d, pick_own;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wait_q, wait_d;
  logic m_req_q, m_req_d, m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic i_ack_q, i_ack_d, i_err_q, i_err_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic done;
  mem_arb_pick #(.D_BURST(D_BURST), .SW(SW)) u_pick (
    .i_req_i(i_req),
    .d_req_i(d_req),
    .d_streak_i(streak_q),
    .own_o(pick_own)
  );
  // m_ack is checked before the timeout so a late ack still completes normally
  always_comb done = m_ack || wait_q == W_LAST;
  always_comb begin
    state_d = state_q;
    own_d = own_q;
    streak_d = streak_q;
    wait_d = wait_q;
    m_req_d = m_req_q;
    m_we_d = m_we_q;
    m_addr_d = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d = 1'b0;
    i_err_d = 1'b0;
    d_ack_d = 1'b0;
    d_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!i_req) streak_d = '0;
        if (i_req || d_req) begin
          state_d = BUSY;
          own_d = pick_own;
          m_req_d = 1'b1;
          m_addr_d = pick_own == OWN_D ? d_addr : i_addr;
          m_we_d = pick_own == OWN_D && d_we;
          m_wdata_d = pick_own == OWN_D ? d_wdata : '0;
          if (pick_own == OWN_I) streak_d = '0;
          else if (i_req && streak_q != D_MAX) streak_d = streak_q + 1'b1;
        end
      end
      BUSY: begin
        wait_d = done ? wait_q : wait_q + 1'b1;
        if (done) begin
          state_d = RESP;
          m_req_d = 1'b0;
          i_ack_d = own_q == OWN_I;
          d_ack_d = own_q == OWN_D;
          i_err_d = own_q == OWN_I && !m_ack;
          d_err_d = own_q == OWN_D && !m_ack;
          i_rdata_d = own_q == OWN_I ? (m_ack ? m_rdata : '0) : i_rdata_q;
          d_rdata_d = own_q == OWN_D ? (m_ack ? m_rdata : '0) : d_rdata_q;
        end
      end
      RESP: begin
        wait_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      own_q <= OWN_I;
      streak_q <= '0;
      wait_q <= '0;
      m_req_q <= 1'b0;
      m_we_q <= 1'b0;
      m_addr_q <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      streak_q <= streak_d;
      wait_q <= wait_d;
      m_req_q <= m_req_d;
      m_we_q <= m_we_d;
      m_addr_q <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q <= i_ack_d;
      i_err_q <= i_err_d;
      d_ack_q <= d_ack_d;
      d_err_q <= d_err_d;
    end
  end
  assign m_req = m_req_q;
  assign m_we = m_we_q;
  assign m_addr = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign i_ack = i_ack_q;
  assign i_err = i_err_q;
  assign d_rdata = d_rdata_q;
  assign d_ack = d_ack_q;
  assign d_err = d_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DB = 4;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic reset;
  logic i_req, d_req, d_we, m_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic i_ack, i_err, d_ack, d_err, m_req, m_we;
  int n_tests = 0;
  int n_fail = 0;
  logic [DW-1:0] mem [16];
  int cnt = 0;
  int lat_cur = 1;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_BURST(DB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );
  // memory responder: acks in the lat_cur-th cycle that m_req is seen high
  task automatic mem_drive();
    if (m_req) begin
      cnt++;
      m_ack = (cnt == lat_cur);
      m_rdata = m_ack ? mem[m_addr[3:0]] : $urandom;
      if (m_ack && m_we) mem[m_addr[3:0]] = m_wdata;
    end else begin
      cnt = 0;
      m_ack = 1'b0;
      m_rdata = $urandom;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    mem_drive();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({m_req, m_we, i_ack, i_err, d_ack, d_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000", {m_req, m_we, i_ack, i_err, d_ack, d_err});
    end
    n_tests++;
    if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h expected all zero", m_addr, m_wdata, i_rdata, d_rdata);
    end
    reset = 1'b0;
  endtask
  task automatic test_fetch();
    mem[0] = 32'hDEADBEEF;
    lat_cur = 1;
    i_addr = 32'h10;
    i_req = 1'b1;
    tick();
    n_tests++;
    if ({m_req, m_we} !== 2'b10 || m_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL fetch_issue: m_req=%b m_we=%b m_addr=%h expected 1 0 00000010", m_req, m_we, m_addr);
    end
    tick();
    n_tests++;
    if ({i_ack, i_err, d_ack} !== 3'b100 || i_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL fetch_ack: ack/err/dack=%b rdata=%h expected 100 deadbeef", {i_ack, i_err, d_ack}, i_rdata);
    end
    i_req = 1'b0;
    tick();
    n_tests++;
    if (i_ack !== 1'b0 || m_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_pulse: i_ack=%b m_req=%b expected 0 0", i_ack, m_req);
    end
  endtask
  task automatic test_store();
    int ack_at = 0;
    bit i_seen = 0;
    logic err = 1'b1;
    logic [DW-1:0] rd = '0;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h20;
    d_wdata = 32'h12345678;
    lat_cur = 3;
    tick();
    n_tests++;
    if ({m_req, m_we} !== 2'b11 || m_addr !== 32'h20 || m_wdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL store_issue: m_req/m_we=%b addr=%h wdata=%h expected 11 00000020 12345678", {m_req, m_we}, m_addr, m_wdata);
    end
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (i_ack) i_seen = 1;
      if (d_ack && ack_at == 0) begin
        ack_at = k;
        err = d_err;
        rd = d_rdata;
        d_req = 1'b0;
      end
    end
    n_tests++;
    if (ack_at != 4 || err !== 1'b0 || i_seen) begin
      n_fail++;
      $display("FAIL store_ack: ack cycle=%0d err=%b i_ack_seen=%0d expected 4 0 0", ack_at, err, i_seen);
    end
    n_tests++;
    if (rd !== 32'hDEADBEEF || mem[0] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL store_data: d_rdata=%h mem=%h expected deadbeef 12345678", rd, mem[0]);
    end
  endtask
  task automatic test_simultaneous();
    mem[3] = 32'hA5A50003;
    mem[5] = 32'h5A5A0005;
    i_addr = 32'd3;
    d_addr = 32'd5;
    d_we = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    lat_cur = 1;
    tick();
    n_tests++;
    if (m_req !== 1'b1 || m_addr !== 32'd5 || m_we !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_first_d: m_req=%b m_addr=%h m_we=%b expected 1 00000005 0", m_req, m_addr, m_we);
    end
    tick();
    n_tests++;
    if ({d_ack, i_ack} !== 2'b10 || d_rdata !== 32'h5A5A0005) begin
      n_fail++;
      $display("FAIL sim_d_ack: d_ack/i_ack=%b d_rdata=%h expected 10 5a5a0005", {d_ack, i_ack}, d_rdata);
    end
    d_req = 1'b0;
    tick();
    tick();
    n_tests++;
    if (m_req !== 1'b1 || m_addr !== 32'd3) begin
      n_fail++;
      $display("FAIL sim_then_i: m_req=%b m_addr=%h expected 1 00000003", m_req, m_addr);
    end
    tick();
    n_tests++;
    if ({i_ack, d_ack} !== 2'b10 || i_rdata !== 32'hA5A50003) begin
      n_fail++;
      $display("FAIL sim_i_ack: i_ack/d_ack=%b i_rdata=%h expected 10 a5a50003", {i_ack, d_ack}, i_rdata);
    end
    i_req = 1'b0;
    tick();
  endtask
  task automatic test_starvation();
    logic [9:0] order = '0;
    int ng = 0;
    logic prev = 1'b0;
    i_addr = 32'd7;
    d_addr = 32'd9;
    d_we = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    lat_cur = 1;
    for (int k = 0; k < 40 && ng < 10; k++) begin
      tick();
      if (m_req && !prev) begin
        order[ng] = (m_addr == 32'd9);
        ng++;
      end
      prev = m_req;
    end
    n_tests++;
    if (ng != 10 || order !== 10'b01111_01111) begin
      n_fail++;
      $display("FAIL starve_order: grants=%0d order(bit0 first,1=D)=%b expected 10 0111101111", ng, order);
    end
    tick();
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
  endtask
  task automatic test_timeout_case(input int lat, input logic exp_err, input logic [DW-1:0] exp_rd);
    int hi = 0;
    bit got = 0;
    logic err = 1'bx;
    logic [DW-1:0] rd = 'x;
    mem[2] = 32'hCAFE0002;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'd2;
    lat_cur = lat;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (m_req) hi++;
      if (d_ack) begin
        got = 1;
        err = d_err;
        rd = d_rdata;
      end
    end
    n_tests++;
    if (!got || hi != TO) begin
      n_fail++;
      $display("FAIL timeout_len(lat=%0d): ack_seen=%0d m_req cycles=%0d expected 1 %0d", lat, got, hi, TO);
    end
    n_tests++;
    if (err !== exp_err || rd !== exp_rd) begin
      n_fail++;
      $display("FAIL timeout_resp(lat=%0d): d_err=%b d_rdata=%h expected %b %h", lat, err, rd, exp_err, exp_rd);
    end
    d_req = 1'b0;
    tick();
  endtask
  task automatic test_timeout();
    test_timeout_case(100, 1'b1, 32'h0);
    test_timeout_case(TO, 1'b0, 32'hCAFE0002);
  endtask
  task automatic test_reset_busy();
    int ia = 0;
    int ack_at = 0;
    logic err = 1'bx;
    logic [DW-1:0] rd = 'x;
    mem[6] = 32'h06000006;
    i_req = 1'b1;
    i_addr = 32'd4;
    lat_cur = 100;
    tick();
    tick();
    tick();
    reset = 1'b1;
    i_req = 1'b0;
    tick();
    n_tests++;
    if ({m_req, m_we, i_ack, i_err, d_ack, d_err} !== 6'b0 || {m_addr, m_wdata, i_rdata, d_rdata} !== 128'b0) begin
      n_fail++;
      $display("FAIL rst_busy_outputs: ctrl=%b addr=%h wdata=%h expected all zero", {m_req, m_we, i_ack, i_err, d_ack, d_err}, m_addr, m_wdata);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (i_ack || m_req) ia++;
    end
    n_tests++;
    if (ia != 0) begin
      n_fail++;
      $display("FAIL rst_busy_quiet: activity cycles=%0d expected 0", ia);
    end
    d_req = 1'b1;
    d_addr = 32'd6;
    d_we = 1'b0;
    lat_cur = 2;
    for (int k = 1; k <= 10 && ack_at == 0; k++) begin
      tick();
      if (d_ack) begin
        ack_at = k;
        err = d_err;
        rd = d_rdata;
      end
    end
    n_tests++;
    if (ack_at != 3 || err !== 1'b0 || rd !== 32'h06000006) begin
      n_fail++;
      $display("FAIL rst_busy_next: ack cycle=%0d err=%b rdata=%h expected 3 0 06000006", ack_at, err, rd);
    end
    d_req = 1'b0;
    tick();
  endtask
  // transaction-level model: grant edge e, ack edge e+min(lat,TO), next sampling edge ack+2
  task automatic test_random();
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] exp_ird, exp_drd, t_wd;
    logic [AW-1:0] t_addr;
    int e, free_at, ack_e, streak, lat;
    bit busy, own_d, t_we, t_err, exp_iack, exp_dack, exp_err;
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    reset = 1'b0;
    foreach (mem[k]) ref_mem[k] = mem[k];
    e = 0;
    free_at = 1;
    ack_e = 0;
    busy = 0;
    own_d = 0;
    t_we = 0;
    t_err = 0;
    t_addr = '0;
    t_wd = '0;
    streak = 0;
    exp_ird = '0;
    exp_drd = '0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      e++;
      exp_iack = 0;
      exp_dack = 0;
      exp_err = 0;
      if (busy && e == ack_e) begin
        busy = 0;
        free_at = e + 2;
        exp_err = t_err;
        if (own_d) begin
          exp_dack = 1;
          exp_drd = t_err ? '0 : ref_mem[t_addr[3:0]];
        end else begin
          exp_iack = 1;
          exp_ird = t_err ? '0 : ref_mem[t_addr[3:0]];
        end
        if (!t_err && t_we) ref_mem[t_addr[3:0]] = t_wd;
      end else if (!busy && e >= free_at) begin
        if (!i_req) streak = 0;
        if (i_req || d_req) begin
          own_d = d_req && !(i_req && streak == DB);
          streak = (own_d && i_req) ? ((streak < DB) ? streak + 1 : DB) : 0;
          lat = $urandom_range(1, TO + 2);
          lat_cur = lat;
          busy = 1;
          t_err = lat > TO;
          ack_e = e + (t_err ? TO : lat);
          t_addr = own_d ? d_addr : i_addr;
          t_we = own_d && d_we;
          t_wd = own_d ? d_wdata : '0;
        end
      end
      n_tests++;
      if (m_req !== busy) begin
        n_fail++;
        $display("FAIL rand_m_req@%0d: got %b expected %b", e, m_req, busy);
      end
      if (busy) begin
        n_tests++;
        if (m_addr !== t_addr || m_we !== t_we || m_wdata !== t_wd) begin
          n_fail++;
          $display("FAIL rand_m_cmd@%0d: got %h/%b/%h expected %h/%b/%h", e, m_addr, m_we, m_wdata, t_addr, t_we, t_wd);
        end
      end
      n_tests++;
      if ({i_ack, i_err, d_ack, d_err} !== {exp_iack, exp_iack && exp_err, exp_dack, exp_dack && exp_err}) begin
        n_fail++;
        $display("FAIL rand_ack@%0d: got %b expected %b", e, {i_ack, i_err, d_ack, d_err},
                 {exp_iack, exp_iack && exp_err, exp_dack, exp_dack && exp_err});
      end
      n_tests++;
      if (i_rdata !== exp_ird || d_rdata !== exp_drd) begin
        n_fail++;
        $display("FAIL rand_rdata@%0d: got %h/%h expected %h/%h", e, i_rdata, d_rdata, exp_ird, exp_drd);
      end
      mem_drive();
      if (exp_iack || !i_req) begin
        i_req = ($urandom_range(0, 2) == 0);
        i_addr = $urandom_range(0, 15);
      end
      if (exp_dack || !d_req) begin
        d_req = ($urandom_range(0, 2) == 0);
        d_we = $urandom_range(0, 1) == 1;
        d_addr = $urandom_range(0, 15);
        d_wdata = $urandom;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 25; k++) tick();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    i_addr = '0;
    d_addr = '0;
    d_wdata = '0;
    m_ack = 1'b0;
    m_rdata = '0;
    foreach (mem[k]) mem[k] = $urandom | 32'h1;
    test_reset();
    test_fetch();
    test_store();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
